// File: rtl/amci_pkg.sv
`default_nettype none
// ============================================================================
// amci_pkg : AMCI bus widths, field offsets and channel FSM encoding
// Rev 1.0
// ============================================================================
package amci_pkg;

  localparam int AMCI_ADDR_W = 32;
  localparam int AMCI_DATA_W = 32;
  localparam int AMCI_RESP_W = 2;

  // MOSI: waddr | wdata | raddr | write | read (LSB first)
  function automatic int amci_mosi_w(input int aw, input int dw);
    return 2 * aw + dw + 2;
  endfunction

  function automatic int amci_wdata_lsb(input int aw);
    return aw;
  endfunction

  function automatic int amci_raddr_lsb(input int aw, input int dw);
    return aw + dw;
  endfunction

  function automatic int amci_write_bit(input int aw, input int dw);
    return 2 * aw + dw;
  endfunction

  function automatic int amci_read_bit(input int aw, input int dw);
    return 2 * aw + dw + 1;
  endfunction

  // MISO: rdata | widle | ridle | wresp | rresp (LSB first)
  function automatic int amci_miso_w(input int dw);
    return dw + 6;
  endfunction

  function automatic int amci_widle_bit(input int dw);
    return dw;
  endfunction

  function automatic int amci_ridle_bit(input int dw);
    return dw + 1;
  endfunction

  function automatic int amci_wresp_lsb(input int dw);
    return dw + 2;
  endfunction

  function automatic int amci_rresp_lsb(input int dw);
    return dw + 4;
  endfunction

  typedef enum logic [1:0] {
    CH_IDLE       = 2'd0,
    CH_ISSUE      = 2'd1,
    CH_WAIT_START = 2'd2,
    CH_WAIT_DONE  = 2'd3
  } amci_ch_state_e;

endpackage
`default_nettype wire

// File: rtl/amci_rr_channel.sv
`default_nettype none
// ============================================================================
// amci_rr_channel : two-requester buffered round-robin channel with FSM
// Rev 1.0
// ============================================================================
module amci_rr_channel
  import amci_pkg::*;
#(
  parameter int PAYLOAD_W = 32,
  parameter int RSP_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_strobe,
  input  logic [PAYLOAD_W-1:0] req0_payload,
  input  logic [PAYLOAD_W-1:0] req1_payload,
  output logic [1:0]           req_idle,
  output logic [RSP_W-1:0]     req0_rsp,
  output logic [RSP_W-1:0]     req1_rsp,
  input  logic                 m_idle,
  input  logic [RSP_W-1:0]     m_rsp,
  output logic                 m_strobe,
  output logic [PAYLOAD_W-1:0] m_payload
);

  amci_ch_state_e       state_q, state_d;
  logic                 grant_q, grant_d;
  logic [1:0]           pend_q, pend_d;
  logic [1:0]           idle_q, idle_d;
  logic [PAYLOAD_W-1:0] buf0_q, buf0_d;
  logic [PAYLOAD_W-1:0] buf1_q, buf1_d;
  logic [RSP_W-1:0]     rsp0_q, rsp0_d;
  logic [RSP_W-1:0]     rsp1_q, rsp1_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    pend_d    = pend_q;
    idle_d    = idle_q;
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    rsp0_d    = rsp0_q;
    rsp1_d    = rsp1_q;
    payload_d = payload_q;

    // A busy requester cannot overwrite its buffer; its idle stays low until the response.
    if (req_strobe[0] && idle_q[0]) begin
      buf0_d    = req0_payload;
      pend_d[0] = 1'b1;
      idle_d[0] = 1'b0;
    end
    if (req_strobe[1] && idle_q[1]) begin
      buf1_d    = req1_payload;
      pend_d[1] = 1'b1;
      idle_d[1] = 1'b0;
    end

    case (state_q)
      CH_IDLE: begin
        if ((pend_q != 2'b00) && m_idle) begin
          // grant_q doubles as the round-robin pointer (last requester served).
          grant_d   = (pend_q == 2'b11) ? ~grant_q : pend_q[1];
          payload_d = grant_d ? buf1_q : buf0_q;
          state_d   = CH_ISSUE;
        end
      end
      CH_ISSUE: begin
        pend_d[grant_q] = 1'b0;
        state_d         = CH_WAIT_START;
      end
      CH_WAIT_START: begin
        if (!m_idle) begin
          state_d = CH_WAIT_DONE;
        end
      end
      CH_WAIT_DONE: begin
        if (m_idle) begin
          if (grant_q) begin
            rsp1_d = m_rsp;
          end else begin
            rsp0_d = m_rsp;
          end
          idle_d[grant_q] = 1'b1;
          state_d         = CH_IDLE;
        end
      end
      default: state_d = CH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CH_IDLE;
      grant_q   <= 1'b1;
      pend_q    <= 2'b00;
      idle_q    <= 2'b11;
      buf0_q    <= '0;
      buf1_q    <= '0;
      rsp0_q    <= '0;
      rsp1_q    <= '0;
      payload_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      pend_q    <= pend_d;
      idle_q    <= idle_d;
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
      rsp0_q    <= rsp0_d;
      rsp1_q    <= rsp1_d;
      payload_q <= payload_d;
    end
  end

  assign req_idle  = idle_q;
  assign req0_rsp  = rsp0_q;
  assign req1_rsp  = rsp1_q;
  assign m_strobe  = (state_q == CH_ISSUE);
  assign m_payload = payload_q;

endmodule
`default_nettype wire

// File: rtl/amci_arbiter.sv
`default_nettype none
// ============================================================================
// amci_arbiter : two-requester AMCI arbiter with independent write/read channels
// Rev 1.0
// ============================================================================
module amci_arbiter
  import amci_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = AMCI_DATA_W,
  parameter int AXI_ADDR_WIDTH = AMCI_ADDR_W
) (
  input  logic                                                  CLK,
  input  logic                                                  RESET,
  input  logic [amci_mosi_w(AXI_ADDR_WIDTH, AXI_DATA_WIDTH)-1:0] S0_AMCI_MOSI,
  output logic [amci_miso_w(AXI_DATA_WIDTH)-1:0]                 S0_AMCI_MISO,
  input  logic [amci_mosi_w(AXI_ADDR_WIDTH, AXI_DATA_WIDTH)-1:0] S1_AMCI_MOSI,
  output logic [amci_miso_w(AXI_DATA_WIDTH)-1:0]                 S1_AMCI_MISO,
  output logic [amci_mosi_w(AXI_ADDR_WIDTH, AXI_DATA_WIDTH)-1:0] M_AMCI_MOSI,
  input  logic [amci_miso_w(AXI_DATA_WIDTH)-1:0]                 M_AMCI_MISO
);

  localparam int AW        = AXI_ADDR_WIDTH;
  localparam int DW        = AXI_DATA_WIDTH;
  localparam int RW        = AMCI_RESP_W;
  localparam int WDATA_LSB = amci_wdata_lsb(AW);
  localparam int RADDR_LSB = amci_raddr_lsb(AW, DW);
  localparam int WRITE_BIT = amci_write_bit(AW, DW);
  localparam int READ_BIT  = amci_read_bit(AW, DW);
  localparam int WIDLE_BIT = amci_widle_bit(DW);
  localparam int RIDLE_BIT = amci_ridle_bit(DW);
  localparam int WRESP_LSB = amci_wresp_lsb(DW);
  localparam int RRESP_LSB = amci_rresp_lsb(DW);

  logic [1:0]       wr_idle, rd_idle;
  logic [RW-1:0]    s0_wrsp, s1_wrsp;
  logic [RW+DW-1:0] s0_rrsp, s1_rrsp;
  logic             m_wr_strobe, m_rd_strobe;
  logic [AW+DW-1:0] m_wr_payload;
  logic [AW-1:0]    m_rd_payload;

  // Write payload is {wdata, waddr} so it lines up with the MOSI low fields.
  amci_rr_channel #(
    .PAYLOAD_W (AW + DW),
    .RSP_W     (RW)
  ) u_wr_chan (
    .clk          (CLK),
    .rst          (RESET),
    .req_strobe   ({S1_AMCI_MOSI[WRITE_BIT], S0_AMCI_MOSI[WRITE_BIT]}),
    .req0_payload ({S0_AMCI_MOSI[WDATA_LSB +: DW], S0_AMCI_MOSI[0 +: AW]}),
    .req1_payload ({S1_AMCI_MOSI[WDATA_LSB +: DW], S1_AMCI_MOSI[0 +: AW]}),
    .req_idle     (wr_idle),
    .req0_rsp     (s0_wrsp),
    .req1_rsp     (s1_wrsp),
    .m_idle       (M_AMCI_MISO[WIDLE_BIT]),
    .m_rsp        (M_AMCI_MISO[WRESP_LSB +: RW]),
    .m_strobe     (m_wr_strobe),
    .m_payload    (m_wr_payload)
  );

  amci_rr_channel #(
    .PAYLOAD_W (AW),
    .RSP_W     (RW + DW)
  ) u_rd_chan (
    .clk          (CLK),
    .rst          (RESET),
    .req_strobe   ({S1_AMCI_MOSI[READ_BIT], S0_AMCI_MOSI[READ_BIT]}),
    .req0_payload (S0_AMCI_MOSI[RADDR_LSB +: AW]),
    .req1_payload (S1_AMCI_MOSI[RADDR_LSB +: AW]),
    .req_idle     (rd_idle),
    .req0_rsp     (s0_rrsp),
    .req1_rsp     (s1_rrsp),
    .m_idle       (M_AMCI_MISO[RIDLE_BIT]),
    .m_rsp        ({M_AMCI_MISO[RRESP_LSB +: RW], M_AMCI_MISO[0 +: DW]}),
    .m_strobe     (m_rd_strobe),
    .m_payload    (m_rd_payload)
  );

  always_comb begin
    M_AMCI_MOSI                     = '0;
    M_AMCI_MOSI[0 +: AW + DW]       = m_wr_payload;
    M_AMCI_MOSI[RADDR_LSB +: AW]    = m_rd_payload;
    M_AMCI_MOSI[WRITE_BIT]          = m_wr_strobe;
    M_AMCI_MOSI[READ_BIT]           = m_rd_strobe;

    S0_AMCI_MISO                    = '0;
    S0_AMCI_MISO[0 +: DW]           = s0_rrsp[DW-1:0];
    S0_AMCI_MISO[WIDLE_BIT]         = wr_idle[0];
    S0_AMCI_MISO[RIDLE_BIT]         = rd_idle[0];
    S0_AMCI_MISO[WRESP_LSB +: RW]   = s0_wrsp;
    S0_AMCI_MISO[RRESP_LSB +: RW]   = s0_rrsp[DW +: RW];

    S1_AMCI_MISO                    = '0;
    S1_AMCI_MISO[0 +: DW]           = s1_rrsp[DW-1:0];
    S1_AMCI_MISO[WIDLE_BIT]         = wr_idle[1];
    S1_AMCI_MISO[RIDLE_BIT]         = rd_idle[1];
    S1_AMCI_MISO[WRESP_LSB +: RW]   = s1_wrsp;
    S1_AMCI_MISO[RRESP_LSB +: RW]   = s1_rrsp[DW +: RW];
  end

endmodule
`default_nettype wire
